uwoc_rx_deframer: RTL
=====================

# uwoc_rx_deframer

Receive-side counterpart of the UWOC TX chain. Takes the raw photodetector comparator output and recovers bits at the rate selected by `rate_sel`. It hunts for the frame sync word, then checks the payload against a locally regenerated PRBS7 stream and reports bit and error counts for BER measurement. It sits directly downstream of the optical link fed by the TX chain's `tx_bit`, on the same 130 MHz clock.

## Interface
- `SYNC_WORD`, 32'hD391_A6E5, 32-bit frame sync pattern, MSB transmitted first.
- `SYNC_TOL`, 2, maximum Hamming distance (0..32) accepted as a sync match.
- `PAYLOAD_BITS`, 600_000, payload length in bits after the sync word.

Ports:
- `clk_130M`  in  1  130 MHz system clock; all logic in this domain.
- `rst_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  level; 0 forces IDLE.
- `rate_sel`  in  3  bit-period select; same mapping as TX.
- `rx_in`  in  1  asynchronous raw receive line.
- `rx_bit`  out  1  recovered bit.
- `rx_bit_vld`  out  1  1-cycle strobe, `rx_bit` valid.
- `lock`  out  1  high from sync match until frame end.
- `busy`  out  1  high in HUNT or PAYLOAD.
- `done`  out  1  1-cycle pulse at frame end.
- `bit_cnt`  out  32  payload bits checked in current/last frame.
- `err_cnt`  out  32  payload bit errors in current/last frame, saturating.
- `dbg_sample_tick`  out  1  mirror of the internal sample strobe.

## Operation
- **Bit period P, in clocks, from `rate_sel`:**
  - 0 → 1300
  - 1 → 130
  - 2 → 26
  - 3 → 13
  - 4–7 → 10
  - `rate_sel` is sampled only on the IDLE→HUNT transition.
- **Clock recovery:**
  - `rx_in` passes a 2-FF synchronizer, then a 1-FF edge detector.
  - Phase counter runs 0..P-1 and wraps.
  - Any detected edge forces the counter to 0 on the next cycle.
  - Sample strobe fires when counter == P>>1.
  - The sampled bit is the synchronized level.
- **PRBS7 reference:**
  - LFSR is 7 bits, seed 7'h7F.
  - expected = lfsr[6]^lfsr[5]; lfsr <= {lfsr[5:0], expected}; advances once per payload bit.
  - First expected bits: 0,0,0,0,0,0,1.
  - This is identical to TX `prbs_gen` with `prbs_sel`=0.
- **FSM (IDLE, HUNT, PAYLOAD, DONE):**
  - IDLE: counters and phase held. `enable`=1 → HUNT next cycle.
  - HUNT: 32-bit shift register, shifting in MSB-first, updated on each strobe. When popcount(shreg ^ `SYNC_WORD`) ≤ `SYNC_TOL`, go to PAYLOAD, set `lock`, clear `bit_cnt`/`err_cnt`, and reload the LFSR seed.
  - PAYLOAD: on each strobe, `bit_cnt`+1; if `rx_bit` != expected, `err_cnt`+1, saturating at 32'hFFFF_FFFF. When `bit_cnt` reaches `PAYLOAD_BITS` → DONE.
  - DONE: one cycle. `done`=1, `lock`=0, then back to HUNT, clearing the shift register.
- `enable`=0 in any state: IDLE next cycle. `lock` and `busy` drop, `done` is not pulsed, and `bit_cnt`/`err_cnt` hold their values.
- `bit_cnt`/`err_cnt` hold the last frame's values until the next sync match.
- `rx_bit`/`rx_bit_vld` are produced in every state except IDLE.

## Timing
- **Reset values:**
  - All outputs 0, FSM in IDLE.
  - LFSR 7'h7F, phase counter 0, shift register 0.
- **Latency:**
  - `rx_in` edge → counter reload takes 3 cycles (2 sync + 1 detect).
  - `rx_bit_vld` is asserted the cycle after the strobe, with `rx_bit` registered.
  - A sync match is evaluated on the updated shift register; `lock` rises 1 cycle after the `rx_bit_vld` of the last sync bit.
  - `bit_cnt`/`err_cnt` update 1 cycle after the corresponding `rx_bit_vld`.
  - `done` is asserted the cycle after `bit_cnt` reaches `PAYLOAD_BITS`.
- **Simultaneous events:**
  - An edge on the strobe cycle: the strobe still fires, then the counter reloads.
  - `enable` falling on the same cycle as the sync match: IDLE wins.
- Sync match requires 32 bits shifted since entering HUNT; the shift-register fill count gates the compare.
- `rst_n` asserted mid-frame clears everything asynchronously. No `done` pulse is produced.

## Test plan
- **Clean frame:** `rate_sel`=3; drive `rx_in` at P=13 with 64 bits of 1010…, then `SYNC_WORD`, then 600_000 PRBS7 bits. Required: `lock` rises, then `done` pulse, `bit_cnt`=600000, `err_cnt`=0.
- **Injected errors:** same stimulus with payload bits 10, 1000 and 599_999 inverted. Required: `err_cnt`=3, `bit_cnt`=600000.
- **Sync tolerance:** 2 bits flipped in the sync word → lock. 3 bits flipped → no lock, stays in HUNT, `busy`=1, `done` never asserted.
- **Clock drift:** `rate_sel`=1 with TX at 131 clocks/bit for 10_000 bits. Required: edge realignment keeps `err_cnt`=0.
- **Disable mid-payload:** drop `enable` after 5000 payload bits. Required: IDLE next cycle, `lock`=0, `busy`=0, no `done` pulse, `bit_cnt`=5000 held.
- **Reset mid-payload:** assert `rst_n`=0 for 1 cycle. Required: all outputs 0 immediately; after re-enable, the next frame completes with `err_cnt`=0.

Source files
------------

// File: rtl/uwoc_rx_deframer.sv
// UWOC receive deframer: recovers bits from the raw comparator line, hunts for the
// frame sync word, then checks the payload against a local PRBS7 for BER counting.
module uwoc_rx_deframer #(
  parameter logic [31:0] SYNC_WORD    = 32'hD391_A6E5,
  parameter int unsigned SYNC_TOL     = 2,
  parameter int unsigned PAYLOAD_BITS = 600_000
) (
  input  logic        clk_130M,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [2:0]  rate_sel,
  input  logic        rx_in,
  output logic        rx_bit,
  output logic        rx_bit_vld,
  output logic        lock,
  output logic        busy,
  output logic        done,
  output logic [31:0] bit_cnt,
  output logic [31:0] err_cnt,
  output logic        dbg_sample_tick
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HUNT = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [31:0] LP_PAY  = 32'(PAYLOAD_BITS);
  localparam logic [5:0]  LP_TOL  = 6'(SYNC_TOL);
  localparam logic [6:0]  LP_SEED = 7'h7F;

  logic [1:0]  r_state;
  logic [1:0]  w_nxt;
  logic        r_sync1, r_sync2, r_prev;
  logic [10:0] r_period;
  logic [10:0] r_phase;
  logic [10:0] w_period_sel;
  logic [31:0] r_shreg;
  logic [5:0]  r_fill;
  logic [6:0]  r_lfsr;
  logic [31:0] r_bit_cnt;
  logic [31:0] r_err_cnt;
  logic        r_rx_bit;
  logic        r_rx_bit_vld;

  logic        w_edge;
  logic        w_tick;
  logic        w_exp;
  logic [31:0] w_diff;
  logic [5:0]  w_dist;
  logic        w_match;
  logic        w_enter_hunt;

  always_comb begin
    case (rate_sel)
      3'd0:    w_period_sel = 11'd1300;
      3'd1:    w_period_sel = 11'd130;
      3'd2:    w_period_sel = 11'd26;
      3'd3:    w_period_sel = 11'd13;
      default: w_period_sel = 11'd10;
    endcase
  end

  assign w_edge = r_sync2 ^ r_prev;
  assign w_tick = (r_state != S_IDLE) && (r_phase == (r_period >> 1));
  assign w_exp  = r_lfsr[6] ^ r_lfsr[5];
  assign w_diff = r_shreg ^ SYNC_WORD;

  always_comb begin
    w_dist = 6'd0;
    for (int i = 0; i < 32; i++) w_dist = w_dist + 6'(w_diff[i]);
  end

  // Only compare once a full word has been shifted in since entering HUNT.
  assign w_match = (r_fill == 6'd32) && (w_dist <= LP_TOL);

  always_comb begin
    w_nxt = r_state;
    if (!enable) begin
      w_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_nxt = S_HUNT;
        S_HUNT:  if (w_match) w_nxt = S_PAY;
        S_PAY:   if (r_bit_cnt == LP_PAY) w_nxt = S_DONE;
        default: w_nxt = S_HUNT;
      endcase
    end
  end

  assign w_enter_hunt = (w_nxt == S_HUNT) && (r_state != S_HUNT);

  always_ff @(posedge clk_130M or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Phase counter: free-running bit clock, re-centred on every line transition.
  always_ff @(posedge clk_130M or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= 11'd1300;
      r_phase  <= 11'd0;
    end else begin
      if (r_state == S_IDLE && w_nxt == S_HUNT) r_period <= w_period_sel;
      if (r_state != S_IDLE) begin
        if (w_edge)                            r_phase <= 11'd0;
        else if (r_phase >= r_period - 11'd1)  r_phase <= 11'd0;
        else                                   r_phase <= r_phase + 11'd1;
      end
    end
  end

  always_ff @(posedge clk_130M or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_bit     <= 1'b0;
      r_rx_bit_vld <= 1'b0;
    end else begin
      r_rx_bit_vld <= w_tick;
      if (w_tick) r_rx_bit <= r_sync2;
    end
  end

  always_ff @(posedge clk_130M or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= 32'd0;
      r_fill  <= 6'd0;
    end else if (w_enter_hunt) begin
      r_shreg <= 32'd0;
      r_fill  <= 6'd0;
    end else if (r_state == S_HUNT && w_tick) begin
      r_shreg <= {r_shreg[30:0], r_sync2};
      if (r_fill != 6'd32) r_fill <= r_fill + 6'd1;
    end
  end

  // Counters are checked against the registered bit, one cycle behind rx_bit_vld.
  always_ff @(posedge clk_130M or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr    <= LP_SEED;
      r_bit_cnt <= 32'd0;
      r_err_cnt <= 32'd0;
    end else if (r_state == S_HUNT && w_nxt == S_PAY) begin
      r_lfsr    <= LP_SEED;
      r_bit_cnt <= 32'd0;
      r_err_cnt <= 32'd0;
    end else if (r_state == S_PAY && enable && r_rx_bit_vld) begin
      r_lfsr    <= {r_lfsr[5:0], w_exp};
      r_bit_cnt <= r_bit_cnt + 32'd1;
      if (r_rx_bit != w_exp && r_err_cnt != 32'hFFFF_FFFF)
        r_err_cnt <= r_err_cnt + 32'd1;
    end
  end

  assign rx_bit          = r_rx_bit;
  assign rx_bit_vld      = r_rx_bit_vld;
  assign lock            = (r_state == S_PAY);
  assign busy            = (r_state == S_HUNT) || (r_state == S_PAY);
  assign done            = (r_state == S_DONE);
  assign bit_cnt         = r_bit_cnt;
  assign err_cnt         = r_err_cnt;
  assign dbg_sample_tick = w_tick;

endmodule
